// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles everything between mem_ctrl and the outside world
// except clk/rst.
//   rdy, rollback           global enable and misprediction flush
//   if_*                    instruction-fetch requester (IF_LEN-byte reads)
//   lsb_*                   load/store buffer requester (1/2/4-byte accesses)
//   mem_*, io_buffer_full   byte-wide RAM/IO port
// slave  : seen from mem_ctrl
// master : seen from the requesters / RAM side (testbench)
interface mem_ctrl_if #(
  parameter int IF_LEN = 4
);
  logic                  rdy;
  logic                  rollback;
  logic                  if_en;
  logic [31:0]           if_addr;
  logic                  if_done;
  logic [IF_LEN*8-1:0]   if_data;
  logic                  lsb_en;
  logic                  lsb_wr;
  logic [31:0]           lsb_addr;
  logic [2:0]            lsb_len;
  logic [31:0]           lsb_w_data;
  logic                  lsb_done;
  logic [31:0]           lsb_r_data;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [31:0]           mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport slave (
    input  rdy, rollback, if_en, if_addr, lsb_en, lsb_wr, lsb_addr, lsb_len,
           lsb_w_data, mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, rollback, if_en, if_addr, lsb_en, lsb_wr, lsb_addr, lsb_len,
           lsb_w_data, mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM/IO port between instruction fetch
// and the load/store buffer. Each request is split into per-byte bus cycles;
// read bytes are reassembled little-endian.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        mem_ctrl_if.slave (requesters, RAM port, rdy, rollback)
// Build option:
//   MEMCTRL_FAIR_ARB_EN  round-robin grant on simultaneous requests in IDLE;
//                        undefined = fixed LSB priority.
// Timing: mem_din in a cycle holds the byte addressed by mem_a one cycle
// earlier. Reads finish (done) in cycle n+1, writes in cycle n, counting
// cycle 0 as the cycle after the accepting edge.
module mem_ctrl #(
  parameter int IF_LEN = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  localparam int BUF_B = (IF_LEN > 4) ? IF_LEN : 4;
  localparam int BUF_W = BUF_B * 8;

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;       // reads: cycle index; stores: bytes launched
  logic [6:0]          len_q, len_d;
  logic [31:0]         base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [31:0]         mem_a_q, mem_a_d;
  logic                mem_wr_q, mem_wr_d;
  logic [7:0]          dout_q, dout_d;
  logic                if_done_q, if_done_d;
  logic [IF_LEN*8-1:0] if_data_q, if_data_d;
  logic                lsb_done_q, lsb_done_d;
  logic [31:0]         lsb_r_data_q, lsb_r_data_d;
`ifdef MEMCTRL_FAIR_ARB_EN
  logic                last_lsb_q, last_lsb_d;  // 1 = LSB granted last
`endif

  // The RAM keeps returning data while rdy is low, but mem_a is frozen, so the
  // byte in flight at the first frozen edge would be overwritten on mem_din.
  // Park it here and use it at the first edge after rdy returns.
  logic                rdy_prev_q;
  logic [7:0]          din_q;
  logic [7:0]          din_sel;
  assign din_sel = rdy_prev_q ? bus.mem_din : din_q;

  logic lsb_ok, if_ok, grant_lsb, grant_if;
  logic [31:0] st_addr;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // Done suppresses the same requester's en so a held request is not replayed.
  // Reads are blocked in a rollback cycle; stores are not.
  assign lsb_ok = bus.lsb_en && !lsb_done_q && (bus.lsb_wr || !bus.rollback);
  assign if_ok  = bus.if_en && !if_done_q && !bus.rollback;

`ifdef MEMCTRL_FAIR_ARB_EN
  assign grant_lsb = lsb_ok && (!if_ok || !last_lsb_q);
`else
  assign grant_lsb = lsb_ok;
`endif
  assign grant_if  = if_ok && !grant_lsb;

  assign st_addr = base_q + {25'd0, cnt_q};

  // state register
  always_ff @(posedge clk) begin
    if (rst)          state_q <= IDLE;
    else if (bus.rdy) state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_lsb)     state_d = bus.lsb_wr ? STORE : LOAD;
        else if (grant_if) state_d = IFETCH;
      end
      IFETCH, LOAD: begin
        if (bus.rollback || cnt_q == len_q) state_d = IDLE;
      end
      STORE: begin
        if (cnt_q == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs / datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_wr_d     = 1'b0;
    dout_d       = dout_q;
    if_done_d    = 1'b0;
    if_data_d    = if_data_q;
    lsb_done_d   = 1'b0;
    lsb_r_data_d = lsb_r_data_q;
`ifdef MEMCTRL_FAIR_ARB_EN
    last_lsb_d   = last_lsb_q;
`endif
    case (state_q)
      IDLE: begin
        mem_a_d = 32'd0;
        if (grant_lsb) begin
`ifdef MEMCTRL_FAIR_ARB_EN
          last_lsb_d = 1'b1;
`endif
          base_d  = bus.lsb_addr;
          len_d   = {4'd0, bus.lsb_len};
          wdata_d = bus.lsb_w_data;
          buf_d   = '0;
          mem_a_d = bus.lsb_addr;
          cnt_d   = 7'd0;
          if (bus.lsb_wr && !(is_io(bus.lsb_addr) && bus.io_buffer_full)) begin
            mem_wr_d = 1'b1;
            dout_d   = bus.lsb_w_data[7:0];
            cnt_d    = 7'd1;
          end
        end else if (grant_if) begin
`ifdef MEMCTRL_FAIR_ARB_EN
          last_lsb_d = 1'b0;
`endif
          base_d  = bus.if_addr;
          len_d   = 7'(IF_LEN);
          buf_d   = '0;
          mem_a_d = bus.if_addr;
          cnt_d   = 7'd0;
        end
      end
      IFETCH, LOAD: begin
        if (bus.rollback) begin
          mem_a_d = 32'd0;
          cnt_d   = 7'd0;
        end else begin
          // byte k arrives one cycle after its address, i.e. at cycle k+1
          if (cnt_q != 7'd0) buf_d[(int'(cnt_q) - 1) * 8 +: 8] = din_sel;
          if (cnt_q == len_q) begin
            mem_a_d = 32'd0;
            cnt_d   = 7'd0;
            if (state_q == IFETCH) begin
              if_done_d = 1'b1;
              if_data_d = buf_d[IF_LEN*8-1:0];
            end else begin
              lsb_done_d   = 1'b1;
              lsb_r_data_d = buf_d[31:0];
            end
          end else begin
            cnt_d   = cnt_q + 7'd1;
            mem_a_d = (cnt_q + 7'd1 < len_q) ? base_q + {25'd0, cnt_q} + 32'd1 : 32'd0;
          end
        end
      end
      STORE: begin
        if (cnt_q == len_q) begin
          lsb_done_d = 1'b1;
          mem_a_d    = 32'd0;
          cnt_d      = 7'd0;
        end else begin
          mem_a_d = st_addr;
          // a full IO FIFO turns this launch into a stall; retry next cycle
          if (!(is_io(st_addr) && bus.io_buffer_full)) begin
            mem_wr_d = 1'b1;
            dout_d   = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d    = cnt_q + 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      dout_q       <= '0;
      if_done_q    <= 1'b0;
      if_data_q    <= '0;
      lsb_done_q   <= 1'b0;
      lsb_r_data_q <= '0;
      rdy_prev_q   <= 1'b0;
      din_q        <= '0;
`ifdef MEMCTRL_FAIR_ARB_EN
      last_lsb_q   <= 1'b0;
`endif
    end else begin
      rdy_prev_q <= bus.rdy;
      if (rdy_prev_q) din_q <= bus.mem_din;
      if (bus.rdy) begin
        cnt_q        <= cnt_d;
        len_q        <= len_d;
        base_q       <= base_d;
        wdata_q      <= wdata_d;
        buf_q        <= buf_d;
        mem_a_q      <= mem_a_d;
        mem_wr_q     <= mem_wr_d;
        dout_q       <= dout_d;
        if_done_q    <= if_done_d;
        if_data_q    <= if_data_d;
        lsb_done_q   <= lsb_done_d;
        lsb_r_data_q <= lsb_r_data_d;
`ifdef MEMCTRL_FAIR_ARB_EN
        last_lsb_q   <= last_lsb_d;
`endif
      end
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = dout_q;
  assign bus.mem_wr     = mem_wr_q & bus.rdy;
  assign bus.if_done    = if_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_done   = lsb_done_q;
  assign bus.lsb_r_data = lsb_r_data_q;
endmodule
